// File: rtl/lane_gate_arbiter.sv
// Round-robin arbiter that lends the single gate controller to one entry lane at a time.
// It forwards the granted lane's signals and ends the session on controller status, withdrawal or PIN timeout.
module lane_gate_arbiter #(
    parameter int NUM_LANES   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [NUM_LANES-1:0]     Lane_req,
    input  logic [8*NUM_LANES-1:0]   Lane_pin,
    input  logic [NUM_LANES-1:0]     Lane_enter,
    input  logic [NUM_LANES-1:0]     Lane_termino,
    input  logic                     Ctl_Abierto,
    input  logic                     Ctl_Cerrado,
    input  logic                     Ctl_Bloqueo,
    output logic                     Vehiculo,
    output logic [7:0]               Pin,
    output logic                     enterPin,
    output logic                     Termino,
    output logic [NUM_LANES-1:0]     Grant,
    output logic                     Busy,
    output logic                     Timeout,
    output logic                     Lock_out
);

    localparam int IW = $clog2(NUM_LANES);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0]        LAST_LANE = IW'(NUM_LANES - 1);
    localparam logic [IW:0]          LANES_W   = (IW + 1)'(NUM_LANES);
    localparam logic [TW-1:0]        T_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [NUM_LANES-1:0] ONE_HOT0  = NUM_LANES'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_PIN = 3'd1,
        S_OPEN     = 3'd2,
        S_LOCKED   = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LANES-1:0]   r_grant;
    logic [IW-1:0]          r_gidx;
    logic [IW-1:0]          r_rr_ptr;
    logic [TW-1:0]          r_timer;
    logic                   r_busy;
    logic                   r_timeout;
    logic                   r_lock_out;

    logic                   w_veh;
    logic [7:0]             w_pin;
    logic                   w_ent_raw;
    logic                   w_trm_raw;
    logic                   w_enter;
    logic                   w_termino;
    logic                   w_expire;
    logic                   w_found;
    logic [IW-1:0]          w_pick;
    logic [IW:0]            w_sum;
    logic [IW-1:0]          w_idx;

    // Select the granted lane's inputs; with no grant every muxed value is zero.
    always_comb begin
        w_veh     = |(Lane_req & r_grant);
        w_ent_raw = |(Lane_enter & r_grant);
        w_trm_raw = |(Lane_termino & r_grant);
        w_pin     = 8'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_pin = w_pin | (Lane_pin[8*i +: 8] & {8{r_grant[i]}});
        end
    end

    // enterPin only matters while a PIN is expected; Termino only once the gate is open.
    always_comb begin
        w_enter   = w_ent_raw & ((r_state == S_WAIT_PIN) || (r_state == S_LOCKED));
        w_termino = w_trm_raw & (r_state == S_OPEN);
    end

    // Round-robin search: first requesting lane at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = {IW{1'b0}};
        w_sum   = {(IW+1){1'b0}};
        w_idx   = {IW{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IW + 1)'(k);
            if (w_sum >= LANES_W) begin
                w_sum = w_sum - LANES_W;
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && Lane_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Session state transitions; Bloqueo beats Abierto, withdrawal beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nxt = S_WAIT_PIN;
                else         w_state_nxt = S_IDLE;
            end
            S_WAIT_PIN: begin
                if (Ctl_Bloqueo)      w_state_nxt = S_LOCKED;
                else if (Ctl_Abierto) w_state_nxt = S_OPEN;
                else if (!w_veh)      w_state_nxt = S_RELEASE;
                else if ((r_timer >= T_LAST) && !w_enter) begin
                    w_state_nxt = S_RELEASE;
                    w_expire    = 1'b1;
                end else begin
                    w_state_nxt = S_WAIT_PIN;
                end
            end
            S_OPEN: begin
                if (Ctl_Bloqueo)                       w_state_nxt = S_LOCKED;
                else if (Ctl_Cerrado && !Ctl_Abierto)  w_state_nxt = S_RELEASE;
                else                                   w_state_nxt = S_OPEN;
            end
            S_LOCKED: begin
                if (Ctl_Abierto) w_state_nxt = S_OPEN;
                else             w_state_nxt = S_LOCKED;
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State, status flags and grant bookkeeping.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_grant    <= {NUM_LANES{1'b0}};
            r_gidx     <= {IW{1'b0}};
            r_rr_ptr   <= {IW{1'b0}};
            r_timer    <= {TW{1'b0}};
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_lock_out <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timeout  <= w_expire;
            r_lock_out <= (w_state_nxt == S_LOCKED);
            if ((r_state == S_IDLE) && w_found) begin
                r_grant <= ONE_HOT0 << w_pick;
                r_gidx  <= w_pick;
                r_busy  <= 1'b1;
                r_timer <= {TW{1'b0}};
            end else if (w_state_nxt == S_RELEASE) begin
                r_grant  <= {NUM_LANES{1'b0}};
                r_busy   <= 1'b0;
                r_timer  <= {TW{1'b0}};
                r_rr_ptr <= (r_gidx == LAST_LANE) ? {IW{1'b0}} : (r_gidx + IW'(1));
            end else if (r_state == S_WAIT_PIN) begin
                r_timer <= w_enter ? {TW{1'b0}} : (r_timer + TW'(1));
            end else begin
                r_timer <= r_timer;
            end
        end
    end

    assign Vehiculo = w_veh;
    assign Pin      = w_pin;
    assign enterPin = w_enter;
    assign Termino  = w_termino;
    assign Grant    = r_grant;
    assign Busy     = r_busy;
    assign Timeout  = r_timeout;
    assign Lock_out = r_lock_out;

endmodule

// File: doc/lane_gate_arbiter.md
Name: lane_gate_arbiter

Overview:
- Shares the single gate controller among NUM_LANES entry lanes.
- Grants one lane at a time, round-robin. It muxes that lane's vehicle, PIN, enter and done signals into the controller.
- Tracks the controller's Abierto/Cerrado/Bloqueo status to decide when the session ends.
- Sits between the lane keypads/sensors and the controller. It also enforces a PIN-entry timeout so an idle lane cannot hold the gate.

Parameters:
- NUM_LANES, 4: number of requesting lanes, 2..8.
- TIMEOUT_CYC, 16: cycles allowed in WAIT_PIN without an enterPin pulse before the grant is revoked.

Ports:
- Clk, input, 1: single clock, rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Lane_req, input, NUM_LANES: vehicle present at lane i.
- Lane_pin, input, 8*NUM_LANES: PIN of lane i in bits [8i+7:8i].
- Lane_enter, input, NUM_LANES: enter pulse of lane i.
- Lane_termino, input, NUM_LANES: vehicle from lane i has finished entering.
- Ctl_Abierto, input, 1: controller status, gate open.
- Ctl_Cerrado, input, 1: controller status, gate closed.
- Ctl_Bloqueo, input, 1: controller status, gate blocked.
- Vehiculo, output, 1: to controller; granted lane's Lane_req.
- Pin, output, 8: to controller; granted lane's PIN.
- enterPin, output, 1: to controller; granted lane's enter pulse.
- Termino, output, 1: to controller; granted lane's Lane_termino.
- Grant, output, NUM_LANES: one-hot granted lane, registered.
- Busy, output, 1: a session is active (Grant != 0), registered.
- Timeout, output, 1: one-cycle pulse when a grant is revoked by timeout.
- Lock_out, output, 1: arbiter is held in LOCKED state.

Behaviour:
- Reset low, asynchronous:
  - state=IDLE, Grant=0, Busy=0, Timeout=0, Lock_out=0, rr_ptr=0, timer=0.
  - Muxed outputs (Vehiculo, Pin, enterPin, Termino) are 0 because Grant=0.
  - Applies immediately mid-session; no drain.
- Muxed outputs are combinational from the registered Grant and the lane inputs.
  - Non-granted lanes' inputs are ignored entirely.
  - Pin=0 when no grant.
- State machine: IDLE, WAIT_PIN, OPEN, LOCKED, RELEASE. State is registered.
- IDLE:
  - If any Lane_req is set, pick the first requesting lane at or after rr_ptr, with wrap-around.
  - Next cycle: Grant=onehot(lane), Busy=1, state=WAIT_PIN, timer=0.
  - Latency from request to grant is 1 cycle.
- WAIT_PIN:
  - Forwards Vehiculo, Pin and enterPin. Termino=0.
  - Transition priority, first match wins:
    - Ctl_Bloqueo=1 -> LOCKED.
    - Ctl_Abierto=1 -> OPEN.
    - Lane_req[g]=0 -> RELEASE.
    - Timeout.
  - Timer clears on any forwarded enterPin and otherwise increments.
  - When timer==TIMEOUT_CYC-1 and no enterPin this cycle: go to RELEASE and pulse Timeout for 1 cycle.
  - An enterPin on the expiry cycle cancels the timeout.
- OPEN:
  - Forwards Vehiculo and Termino. enterPin=0.
  - Ctl_Bloqueo=1 -> LOCKED.
  - Ctl_Cerrado=1 and Ctl_Abierto=0 -> RELEASE.
  - No timeout in this state.
- LOCKED:
  - Lock_out=1. Forwards Vehiculo, Pin and enterPin. Termino=0.
  - Grant is held and there is no timeout.
  - Ctl_Abierto=1 -> OPEN.
  - Lane_req[g] dropping does not release the grant; the lock must be cleared by a correct PIN.
- RELEASE:
  - Lasts 1 cycle. Grant=0, Busy=0.
  - rr_ptr = (g+1) mod NUM_LANES, regardless of how the session ended (success, withdrawal or timeout). Then go to IDLE.
  - The guaranteed idle cycle lets the controller see Vehiculo=0 between lanes.
- Simultaneous events:
  - Bloqueo and Abierto both set: Bloqueo wins.
  - Requests arriving during a session wait; no pre-emption.
  - The same lane requesting again is served only after the other pending lanes (round-robin fairness).
- Grant is always one-hot or zero. Timer width is clog2(TIMEOUT_CYC+1).

Test Plan:
- Reset low mid-OPEN with Grant=0010 -> same edge: Grant=0, Busy=0, Vehiculo=0, Pin=0. After release, Lane_req=0001 grants 0001 (rr_ptr=0).
- Lane_req=0101 from IDLE, rr_ptr=0 -> Grant=0001. Lane0 enters PIN 0x10, controller Abierto=1 -> OPEN. Termino, then Cerrado=1 -> RELEASE. Next grant=0100.
- Lane1 granted, no enter for 16 cycles -> Timeout pulse on the 16th cycle, RELEASE, rr_ptr=2. Lane2 requesting gets Grant=0100 two cycles later.
- Lane3 granted, enterPin exactly on cycle 15 -> no Timeout, timer=0, still WAIT_PIN.
- OPEN with Ctl_Bloqueo=1 and Ctl_Abierto=1 same cycle -> LOCKED, Lock_out=1. Lane_req drop keeps Grant. Abierto after correct PIN -> OPEN.
- Granted lane2 sends Pin=0x10 while lane0 Lane_enter=1 with Pin=0x99 -> controller sees only Pin=0x10 and lane2's enterPin.
